// File: rtl/da_fft_pkg.sv
// Shared constants and types for the 8-point FFT datapath.
package da_fft_pkg;

  // Default real/imag sample width (two's complement).
  localparam int DEF_DATA_WIDTH = 17;

  // FFT size and the derived address/pair widths.
  localparam int N      = 8;
  localparam int NPAIR  = N / 2;
  localparam int ADDR_W = $clog2(N);
  localparam int IDX_W  = 2;

  // First-stage sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/da_cbfly2.sv
// Combinational radix-2 complex butterfly with unity twiddle.
// Both operands are sign-extended by one bit so the sum/difference
// never overflows.
module da_cbfly2 #(
  parameter int W = 17
) (
  input  logic signed [W-1:0] a_re_i,
  input  logic signed [W-1:0] a_im_i,
  input  logic signed [W-1:0] b_re_i,
  input  logic signed [W-1:0] b_im_i,
  output logic signed [W:0]   sum_re_o,
  output logic signed [W:0]   sum_im_o,
  output logic signed [W:0]   diff_re_o,
  output logic signed [W:0]   diff_im_o
);

  logic signed [W:0] a_re_x, a_im_x, b_re_x, b_im_x;

  assign a_re_x = {a_re_i[W-1], a_re_i};
  assign a_im_x = {a_im_i[W-1], a_im_i};
  assign b_re_x = {b_re_i[W-1], b_re_i};
  assign b_im_x = {b_im_i[W-1], b_im_i};

  assign sum_re_o  = a_re_x + b_re_x;
  assign sum_im_o  = a_im_x + b_im_x;
  assign diff_re_o = a_re_x - b_re_x;
  assign diff_im_o = a_im_x - b_im_x;

endmodule

// File: rtl/da_bfly_stage1.sv
// FFT stage 1: walks the bit-reversed register file pair by pair,
// computes the W0 butterfly and hands each result to the next stage
// over a valid/ready stream. Every output comes straight from a flop.
module da_bfly_stage1
  import da_fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         ren,
  output logic [ADDR_W-1:0]            raddr,
  input  logic signed [DATA_WIDTH-1:0] rd_real,
  input  logic signed [DATA_WIDTH-1:0] rd_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_idx,
  output logic signed [DATA_WIDTH:0]   out_sum_real,
  output logic signed [DATA_WIDTH:0]   out_sum_imag,
  output logic signed [DATA_WIDTH:0]   out_diff_real,
  output logic signed [DATA_WIDTH:0]   out_diff_imag
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NPAIR - 1);

  state_e                   state_q;
  logic [IDX_W-1:0]         k_q;
  logic                     busy_q, done_q, ren_q, out_valid_q;
  logic [ADDR_W-1:0]        raddr_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic signed [DATA_WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [DATA_WIDTH-1:0] b_re_d, b_im_d;
  logic signed [DATA_WIDTH:0]   sr_q, si_q, dr_q, di_q;
  logic signed [DATA_WIDTH:0]   sr_d, si_d, dr_d, di_d;

  // B is the register-file word arriving during CAP; otherwise hold it.
  assign b_re_d = (state_q == CAP) ? rd_real : b_re_q;
  assign b_im_d = (state_q == CAP) ? rd_imag : b_im_q;

  da_cbfly2 #(.W(DATA_WIDTH)) u_bfly (
    .a_re_i   (a_re_q),
    .a_im_i   (a_im_q),
    .b_re_i   (b_re_d),
    .b_im_i   (b_im_d),
    .sum_re_o (sr_d),
    .sum_im_o (si_d),
    .diff_re_o(dr_d),
    .diff_im_o(di_d)
  );

  // Sequencer: read A, read B, capture, then hold the result until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      sr_q        <= '0;
      si_q        <= '0;
      dr_q        <= '0;
      di_q        <= '0;
    end else begin
      done_q <= 1'b0;
      b_re_q <= b_re_d;
      b_im_q <= b_im_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RD_A;
            k_q     <= '0;
            busy_q  <= 1'b1;
            ren_q   <= 1'b1;
            raddr_q <= '0;
          end
        end
        RD_A: begin
          state_q <= RD_B;
          ren_q   <= 1'b1;
          raddr_q <= {k_q, 1'b1};
        end
        RD_B: begin
          // Data for the even address lands this cycle.
          state_q <= CAP;
          ren_q   <= 1'b0;
          a_re_q  <= rd_real;
          a_im_q  <= rd_imag;
        end
        CAP: begin
          state_q     <= OUT;
          out_valid_q <= 1'b1;
          out_idx_q   <= k_q;
          sr_q        <= sr_d;
          si_q        <= si_d;
          dr_q        <= dr_d;
          di_q        <= di_d;
        end
        OUT: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (k_q == K_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD_A;
              k_q     <= k_q + 1'b1;
              ren_q   <= 1'b1;
              raddr_q <= {k_q + 1'b1, 1'b0};
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ren_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign ren           = ren_q;
  assign raddr         = raddr_q;
  assign out_valid     = out_valid_q;
  assign out_idx       = out_idx_q;
  assign out_sum_real  = sr_q;
  assign out_sum_imag  = si_q;
  assign out_diff_real = dr_q;
  assign out_diff_imag = di_q;

endmodule

// File: tb/tb_da_bfly_stage1.sv
// Bench for da_bfly_stage1: emulates the 1-cycle-latency register file
// and checks every accepted result against plain integer butterflies.
module tb_da_bfly_stage1;

  localparam int DW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, ren, out_valid;
  logic [2:0] raddr;
  logic [1:0] out_idx;
  logic signed [DW-1:0] rd_real = '0, rd_imag = '0;
  logic signed [DW:0] out_sum_real, out_sum_imag, out_diff_real, out_diff_imag;

  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];

  int n_chk = 0;
  int n_err = 0;

  da_bfly_stage1 #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .ren          (ren),
    .raddr        (raddr),
    .rd_real      (rd_real),
    .rd_imag      (rd_imag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_sum_real (out_sum_real),
    .out_sum_imag (out_sum_imag),
    .out_diff_real(out_diff_real),
    .out_diff_imag(out_diff_imag)
  );

  always #5 clk = ~clk;

  // Register file read port: data follows ren by one clock.
  always @(posedge clk) begin
    if (ren) begin
      rd_real <= mem_re[raddr];
      rd_imag <= mem_im[raddr];
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int bitrev3(input int i);
    return {29'd0, i[0], i[1], i[2]};
  endfunction

  function automatic logic signed [DW-1:0] rnd17();
    case ($urandom_range(0, 5))
      0:       return DW'(-65536);
      1:       return DW'(65535);
      default: return DW'($urandom);
    endcase
  endfunction

  // Natural-order writes land at bit-reversed addresses.
  task automatic load_ramp();
    for (int n = 0; n < 8; n++) begin
      mem_re[bitrev3(n)] = DW'(n + 1);
      mem_im[bitrev3(n)] = '0;
    end
  endtask

  task automatic load_random();
    for (int n = 0; n < 8; n++) begin
      mem_re[n] = rnd17();
      mem_im[n] = rnd17();
    end
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_done"}, int'(done), 0);
    chk({pfx, "_ren"}, int'(ren), 0);
    chk({pfx, "_raddr"}, int'(raddr), 0);
    chk({pfx, "_valid"}, int'(out_valid), 0);
    chk({pfx, "_idx"}, int'(out_idx), 0);
    chk({pfx, "_sr"}, int'(out_sum_real), 0);
    chk({pfx, "_si"}, int'(out_sum_imag), 0);
    chk({pfx, "_dr"}, int'(out_diff_real), 0);
    chk({pfx, "_di"}, int'(out_diff_imag), 0);
  endtask

  // One frame. cyc counts rising edges after the edge that samples start:
  // first result at 3, done at 16 plus any stall cycles.
  task automatic run_frame(input int stall_k, input int stall_n,
                           input bit mid_start, input bit chain,
                           input bit started);
    int cyc, ek, stalled, acc1, exp_done;
    int ar, ai, br, bi;
    bit first, got_done;
    exp_done = 16 + stall_n;
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; ek = 0; stalled = 0; acc1 = -1; first = 1'b1; got_done = 1'b0;
    while (!got_done) begin
      if (cyc > 200) begin
        chk("frame_timeout", cyc, exp_done);
        break;
      end
      start = (mid_start && acc1 >= 0 && cyc == acc1 + 2);
      if (done) begin
        got_done = 1'b1;
        chk("done_time", cyc, exp_done);
        chk("busy_at_done", int'(busy), 0);
        chk("results", ek, 4);
        start = chain;
      end else begin
        chk("busy", int'(busy), 1);
        if (out_valid) begin
          if (first) begin
            chk("first_latency", cyc, 3);
            first = 1'b0;
          end
          ar = mem_re[2*ek]; ai = mem_im[2*ek];
          br = mem_re[2*ek+1]; bi = mem_im[2*ek+1];
          chk($sformatf("idx_k%0d", ek), int'(out_idx), ek);
          chk($sformatf("sum_re_k%0d", ek), int'(out_sum_real), ar + br);
          chk($sformatf("sum_im_k%0d", ek), int'(out_sum_imag), ai + bi);
          chk($sformatf("dif_re_k%0d", ek), int'(out_diff_real), ar - br);
          chk($sformatf("dif_im_k%0d", ek), int'(out_diff_imag), ai - bi);
          if (ek == stall_k && stalled < stall_n) begin
            out_ready = 1'b0;
            stalled++;
            chk("ren_in_stall", int'(ren), 0);
          end else begin
            out_ready = 1'b1;
            if (ek == 1) acc1 = cyc;
            ek++;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!chain) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
      end
    end
  endtask

  task automatic reset_mid_frame();
    int n;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 2'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_k1", int'(out_valid && out_idx == 2'd1), 1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Ramp x_n = (n+1, 0) through the bit-reversed layout.
    load_ramp();
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0);

    // Extreme operands on pair 1.
    load_random();
    mem_re[2] = DW'(65535);  mem_im[2] = DW'(-65536);
    mem_re[3] = DW'(65535);  mem_im[3] = DW'(65535);
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0);

    // Ten cycles of backpressure on k1.
    load_random();
    run_frame(1, 10, 1'b0, 1'b0, 1'b0);

    // Stray start while busy.
    load_random();
    run_frame(-1, 0, 1'b1, 1'b0, 1'b0);

    // Reset while holding k1, then a clean frame.
    load_random();
    reset_mid_frame();
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames with start raised in the done cycle.
    load_random();
    run_frame(-1, 0, 1'b0, 1'b1, 1'b0);
    run_frame(-1, 0, 1'b0, 1'b0, 1'b1);

    // Random data and random stalls.
    for (int f = 0; f < 6; f++) begin
      load_random();
      run_frame($urandom_range(0, 3), $urandom_range(0, 5), 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/da_bfly_stage1.md
Name: da_bfly_stage1

Overview:
- Downstream consumer of the 8-entry complex bit-reversed register file in the 8-point FFT datapath.
- On start, it reads the four adjacent entry pairs (0,1), (2,3), (4,5), (6,7) through the register file's ren/raddr port, which has 1-cycle read latency.
- For each pair it computes the radix-2 first-stage butterfly: twiddle W0, so adds and subtracts only.
- Results go out on a valid/ready stream to the next FFT stage.

Parameters:
- DATA_WIDTH, 17, width of each real/imag input sample (two's complement); outputs are DATA_WIDTH+1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame-ready pulse from the loader; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last pair is accepted downstream.
- ren  out  1  register-file read enable.
- raddr  out  3  register-file read address.
- rd_real  in  DATA_WIDTH  register-file dout_real; valid the cycle after ren.
- rd_imag  in  DATA_WIDTH  register-file dout_imag.
- out_valid  out  1  butterfly result valid.
- out_ready  in  1  downstream accept.
- out_idx  out  2  pair index k, 0..3.
- out_sum_real  out  DATA_WIDTH+1  a.re + b.re
- out_sum_imag  out  DATA_WIDTH+1  a.im + b.im
- out_diff_real  out  DATA_WIDTH+1  a.re - b.re
- out_diff_imag  out  DATA_WIDTH+1  a.im - b.im

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pair counter k=0.
  - busy, done, ren, raddr, out_valid, out_idx and all out_* data = 0.
  - Captured A/B registers cleared.
- All outputs are registered; no combinational path from out_ready or start to any output.
- FSM:
  - IDLE: start=1 -> RD_A, k=0. Otherwise stay.
  - RD_A: ren=1, raddr={k,1'b0} -> RD_B.
  - RD_B: ren=1, raddr={k,1'b1}; capture rd_* as A -> CAP.
  - CAP: ren=0; capture rd_* as B; register sum/diff into out_*; out_valid=1 next cycle -> OUT.
  - OUT: hold out_* and out_valid until out_valid & out_ready.
    - On accept with k<3: k++, out_valid=0 -> RD_A.
    - On accept with k=3: out_valid=0, done=1 for one cycle -> IDLE.
- ren is low outside RD_A/RD_B; raddr holds its last value when ren=0.
- Latency: start to first out_valid = 4 cycles. With out_ready held high, one result every 4 cycles; a frame completes in 16 cycles from start to done.
- Arithmetic:
  - Sign-extend both operands to DATA_WIDTH+1 before add/sub.
  - No saturation or rounding; full range is representable.
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start in the same cycle done is high: FSM is already in IDLE, so start is accepted and a new frame begins.
  - out_ready high before out_valid: no effect.
  - out_ready low: the FSM stalls in OUT indefinitely with data stable and no further reads issued.
  - rst mid-frame: immediate return to reset state; the partial frame is discarded and no done is issued.

Decomposition:
- Shared package da_fft_pkg holds:
  - DATA_WIDTH default (17).
  - FFT size constant N=8.
  - State encoding enum (IDLE, RD_A, RD_B, CAP, OUT).
  - Pair-index width constant (2).
- One natural sub-module, da_cbfly2: purely combinational complex add/sub with sign extension, reused by later stages.

Test Plan:
- Load samples x_n = (n+1, 0) via the register file's natural-order writes, pulse start, out_ready=1. Required stream:
  - k0: sum (6,0), diff (-4,0).
  - k1: sum (10,0), diff (-4,0).
  - k2: sum (8,0), diff (-4,0).
  - k3: sum (12,0), diff (-4,0).
  - done pulses 16 cycles after start.
- Extremes: A=(65535,-65536), B=(65535,65535). Required sum (131070,-1) and diff (0,-131071) in 18-bit two's complement.
- Backpressure: out_ready=0 for 10 cycles on k1. Required: out_valid held, outputs stable, ren=0 throughout, then resume; total frame time 26 cycles.
- start pulsed during RD_B of k2: ignored, exactly 4 results and a single done.
- rst asserted while in OUT for k1: all outputs 0 asynchronously, no done; a following start yields a full 4-result frame from k0.
- start asserted in the done cycle: the second frame begins immediately, and the first out_valid of frame 2 arrives 4 cycles later.
